// File: rtl/tmds_pkg.sv
// tmds_pkg: shared TMDS control tokens, word type and alignment states.
// Used by the receive-side channel decoder and the transmit-side encoder.
package tmds_pkg;
  typedef logic [9:0] tmds_word_t;
  typedef enum logic [1:0] {SEARCH, SETTLE, LOCKED} align_state_t;
  localparam tmds_word_t CTRL_00 = 10'h354;
  localparam tmds_word_t CTRL_01 = 10'h0AB;
  localparam tmds_word_t CTRL_10 = 10'h154;
  localparam tmds_word_t CTRL_11 = 10'h2AB;
endpackage

// File: rtl/tmds_word_decode.sv
// tmds_word_decode: combinational decode of one 10-bit TMDS word.
//  din     in  10  TMDS word, din[0] first bit on the wire
//  is_ctrl out 1   word is one of the four control tokens
//  c1c0    out 2   control bits carried by the token (0 for data words)
//  dout    out 8   decoded pixel byte (0 for control tokens)
module tmds_word_decode
  import tmds_pkg::*;
(
  input  logic [9:0] din,
  output logic       is_ctrl,
  output logic [1:0] c1c0,
  output logic [7:0] dout
);
  logic [7:0] q;
  logic [7:0] data;
  always_comb begin
    q = din[9] ? ~din[7:0] : din[7:0];
    data = '0;
    data[0] = q[0];
    for (int i = 1; i < 8; i++) data[i] = din[8] ? q[i] ^ q[i-1] : ~(q[i] ^ q[i-1]);
    is_ctrl = (din == CTRL_00) || (din == CTRL_01) || (din == CTRL_10) || (din == CTRL_11);
    c1c0 = (din == CTRL_01) ? 2'b01 : (din == CTRL_10) ? 2'b10 : (din == CTRL_11) ? 2'b11 : 2'b00;
    dout = is_ctrl ? 8'h00 : data;
  end
endmodule

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: per-channel TMDS word alignment (bitslip search) and decode.
//  clk      in  1   pixel clock
//  rst      in  1   asynchronous active-high reset
//  din      in  10  deserialized word, din[0] first bit on the wire
//  dout     out 8   decoded pixel data (valid when de=1)
//  c0, c1   out 1   control bits (hold last control value during data)
//  de       out 1   data enable
//  bitslip  out 1   one-cycle request to shift deserializer framing by one bit
//  locked   out 1   word alignment achieved
//  slip_cnt out 4   slips issued since last lock/reset, wraps 9->0
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN    = 128,
  parameter int TIMEOUT     = 4096,
  parameter int SLIP_SETTLE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  output logic [7:0] dout,
  output logic       c0,
  output logic       c1,
  output logic       de,
  output logic       bitslip,
  output logic       locked,
  output logic [3:0] slip_cnt
);
  localparam int RW = $clog2(CTRL_RUN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(SLIP_SETTLE + 1);
  localparam logic [RW-1:0] RUN_MAX     = RW'(CTRL_RUN);
  localparam logic [TW-1:0] TMO_MAX     = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SLIP_SETTLE - 1);

  align_state_t    state_q, state_d;
  tmds_word_t      din_q;
  logic [RW-1:0]   run_q, run_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [3:0]      slip_cnt_q, slip_cnt_d;
  logic            bitslip_q, bitslip_d;
  logic [7:0]      dout_q, dout_d;
  logic            de_q, de_d;
  logic [1:0]      c_q, c_d;
  logic [1:0]      c_hold_q, c_hold_d;
  logic            is_ctrl;
  logic [1:0]      dec_c;
  logic [7:0]      dec_dout;
  logic [RW-1:0]   run_inc;
  logic [TW-1:0]   tmo_inc;
  logic            timeout;
  logic            pass;

  tmds_word_decode u_dec (
    .din     (din_q),
    .is_ctrl (is_ctrl),
    .c1c0    (dec_c),
    .dout    (dec_dout)
  );

  always_comb begin
    run_inc = (run_q == RUN_MAX) ? run_q : run_q + RW'(1);
    tmo_inc = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TW'(1);
    timeout = !is_ctrl && (tmo_q >= TMO_LAST);
    state_d = state_q;
    run_d = '0;
    tmo_d = '0;
    settle_d = '0;
    slip_cnt_d = slip_cnt_q;
    bitslip_d = 1'b0;
    unique case (state_q)
      SEARCH: begin
        run_d = is_ctrl ? run_inc : '0;
        tmo_d = is_ctrl ? '0 : tmo_inc;
        // a token on the timeout cycle clears tmo_cnt, so it always wins over the slip
        if (is_ctrl && run_inc == RUN_MAX) begin
          state_d = LOCKED;
          slip_cnt_d = '0;
          run_d = '0;
        end else if (timeout) begin
          state_d = SETTLE;
          bitslip_d = 1'b1;
          slip_cnt_d = (slip_cnt_q == 4'd9) ? 4'd0 : slip_cnt_q + 4'd1;
          tmo_d = '0;
        end
      end
      SETTLE: begin
        settle_d = settle_q + SW'(1);
        if (settle_q >= SETTLE_LAST) begin
          state_d = SEARCH;
          settle_d = '0;
        end
      end
      LOCKED: begin
        tmo_d = is_ctrl ? '0 : tmo_inc;
        // loss of lock goes back to SEARCH without slipping; framing may still be right
        if (timeout) begin
          state_d = SEARCH;
          tmo_d = '0;
        end
      end
      default: state_d = SEARCH;
    endcase
    // gate with the next state so outputs open/close on the same edge locked changes
    pass = (state_d == LOCKED);
    c_hold_d = is_ctrl ? dec_c : c_hold_q;
    dout_d = pass ? dec_dout : 8'h00;
    de_d = pass && !is_ctrl;
    c_d = pass ? c_hold_d : 2'b00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEARCH;
      din_q <= '0;
      run_q <= '0;
      tmo_q <= '0;
      settle_q <= '0;
      slip_cnt_q <= '0;
      bitslip_q <= 1'b0;
      dout_q <= '0;
      de_q <= 1'b0;
      c_q <= '0;
      c_hold_q <= '0;
    end else begin
      state_q <= state_d;
      din_q <= din;
      run_q <= run_d;
      tmo_q <= tmo_d;
      settle_q <= settle_d;
      slip_cnt_q <= slip_cnt_d;
      bitslip_q <= bitslip_d;
      dout_q <= dout_d;
      de_q <= de_d;
      c_q <= c_d;
      c_hold_q <= c_hold_d;
    end
  end

  assign dout = dout_q;
  assign de = de_q;
  assign c1 = c_q[1];
  assign c0 = c_q[0];
  assign bitslip = bitslip_q;
  assign locked = (state_q == LOCKED);
  assign slip_cnt = slip_cnt_q;
endmodule
